common_regfile: RTL and testbench
=================================

// Module: common_regfile
// PURPOSE
//  Parametrised multi-entry register bank for the CPU datapath (GPRs, SP, pointers).
//  Provides 1 write/modify port with in-place LOAD/INC/DEC/CLR ops and 2 read ports.
//  Optional write-to-read bypass and hardwired-zero R0. Tracks per-entry "written" status.
//  Sits between decode (addresses/op) and ALU operand muxes.
// PARAMETERS
//  pDATA_WIDTH = 8                  : bits per entry
//  pDEPTH      = 8                  : number of entries, >= 2; need not be a power of 2
//  pADDR_WIDTH = $clog2(pDEPTH)     : address width, derived; do not override
//  pBYPASS     = 1                  : 1 = read ports see the value being written this cycle
//  pZERO_R0    = 0                  : 1 = entry 0 reads as 0 and ignores writes
// PORTS
//  iclk        in   1            clock, rising edge
//  irst_n      in   1            reset, asynchronous, active-low
//  iclr        in   1            synchronous clear of all entries and status
//  iwe         in   1            perform iop on entry iwaddr this cycle
//  iop         in   2            00 LOAD, 01 INC, 10 DEC, 11 CLR (type regfile_op_e)
//  iwaddr      in   pADDR_WIDTH  target entry
//  iwdata      in   pDATA_WIDTH  LOAD data; ignored for other ops
//  iraddr_a    in   pADDR_WIDTH  read port A address
//  ordata_a    out  pDATA_WIDTH  read port A data, combinational
//  iraddr_b    in   pADDR_WIDTH  read port B address
//  ordata_b    out  pDATA_WIDTH  read port B data, combinational
//  owrap       out  1            registered; INC/DEC wrapped on the previous cycle
//  owritten    out  pDEPTH       registered; bit i set once entry i is modified
// BEHAVIOUR
//  Reset (irst_n=0, async): all entries=0, owrap=0, owritten='0. Read data follows the entries.
//  Priority each edge: reset > iclr > iwe.
//  iclr=1: all entries=0, owritten='0, owrap=0. A concurrent iwe is dropped.
//  iwe=1 with a valid address updates the entry at the next rising edge. Result is per iop:
//    LOAD: iwdata.
//    INC: entry+1, modulo 2^pDATA_WIDTH.
//    DEC: entry-1, modulo 2^pDATA_WIDTH.
//    CLR: 0.
//  The same write sets owritten[iwaddr]=1. The bit is sticky until reset or iclr.
//  owrap=1 for exactly one cycle after INC of all-ones or DEC of zero. Otherwise it is 0 each cycle.
//  Invalid write address (iwaddr >= pDEPTH, or iwaddr==0 with pZERO_R0=1):
//    no entry changes, owritten unchanged, owrap=0.
//  Read (0-cycle latency): ordata_x = entry[iraddr_x].
//    Returns 0 if iraddr_x >= pDEPTH, or if iraddr_x==0 with pZERO_R0=1.
//  Bypass (pBYPASS=1): if iwe && !iclr && valid write && iraddr_x==iwaddr,
//    ordata_x = the computed next value (e.g. INC result), not the stored value.
//  pBYPASS=0: reads always return the stored value; the new value is visible the cycle after.
//  Both read ports may address the same entry. They are fully independent of each other.
//  Reset asserted mid-operation: the pending write is lost; no partial update.
// STRUCTURE
//  Package common_regfile_pkg:
//    typedef enum logic [1:0] regfile_op_e {OP_LOAD, OP_INC, OP_DEC, OP_CLR}.
//  Sub-module common_regfile_upd (combinational): inputs cur, iwdata, iop; outputs nxt, wrap.
//    Shared by the write path and the bypass path so both yield identical values.
//  Storage: one always_ff array with async reset. Read muxes are generated per port.
// TESTING (pDATA_WIDTH=8, pDEPTH=8 unless stated)
//  1 Reset/LOAD: after reset all reads=0x00, owritten=0x00.
//    LOAD r3=0xA5, next cycle ordata_a(r3)=0xA5, owritten=0x08.
//  2 Wrap: LOAD r2=0xFF, then INC r2 -> r2=0x00, owrap=1 for one cycle.
//    Then DEC r2 -> 0xFF, owrap=1. Then INC -> 0x00 wraps again; a non-wrapping INC gives owrap=0.
//  3 Bypass: r5=0x10, same cycle INC r5 with iraddr_a=iraddr_b=5 -> both read 0x11 that cycle.
//    Repeat with pBYPASS=0 -> both read 0x10, then 0x11 on the next cycle.
//  4 Zero R0 (pZERO_R0=1): LOAD r0=0x55 -> ordata r0=0x00, owritten[0]=0, owrap stays 0.
//  5 Odd depth (pDEPTH=5): LOAD addr 6 -> no change; read addr 7 -> 0x00.
//  6 Priority: iclr with iwe LOAD r1=0x33 -> all entries 0x00, owritten=0.
//    Async reset pulse mid-INC -> entry 0x00, owrap=0.

Source files
------------

// File: rtl/common_regfile_pkg.sv
// Shared types for the CPU datapath register bank.
package common_regfile_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } regfile_op_e;

endpackage

// File: rtl/common_regfile_upd.sv
// Next-value computation for one register entry; shared by the write and bypass paths.
module common_regfile_upd
  import common_regfile_pkg::*;
#(
  parameter int pDATA_WIDTH = 8
) (
  input  logic [pDATA_WIDTH-1:0] cur,
  input  logic [pDATA_WIDTH-1:0] iwdata,
  input  regfile_op_e            iop,
  output logic [pDATA_WIDTH-1:0] nxt,
  output logic                   wrap
);

  always_comb begin
    nxt  = cur;
    wrap = 1'b0;
    unique case (iop)
      OP_LOAD: nxt = iwdata;
      OP_INC: begin
        nxt  = cur + pDATA_WIDTH'(1);
        wrap = &cur;
      end
      OP_DEC: begin
        nxt  = cur - pDATA_WIDTH'(1);
        wrap = ~|cur;
      end
      OP_CLR: nxt = '0;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/common_regfile.sv
// Multi-entry register bank: one LOAD/INC/DEC/CLR write port, two combinational read ports.
module common_regfile
  import common_regfile_pkg::*;
#(
  parameter int pDATA_WIDTH = 8,
  parameter int pDEPTH      = 8,
  parameter int pADDR_WIDTH = $clog2(pDEPTH),
  parameter int pBYPASS     = 1,
  parameter int pZERO_R0    = 0
) (
  input  logic                   iclk,
  input  logic                   irst_n,
  input  logic                   iclr,
  input  logic                   iwe,
  input  regfile_op_e            iop,
  input  logic [pADDR_WIDTH-1:0] iwaddr,
  input  logic [pDATA_WIDTH-1:0] iwdata,
  input  logic [pADDR_WIDTH-1:0] iraddr_a,
  output logic [pDATA_WIDTH-1:0] ordata_a,
  input  logic [pADDR_WIDTH-1:0] iraddr_b,
  output logic [pDATA_WIDTH-1:0] ordata_b,
  output logic                   owrap,
  output logic [pDEPTH-1:0]      owritten
);

  logic [pDATA_WIDTH-1:0] mem [pDEPTH];
  logic [pDATA_WIDTH-1:0] cur;
  logic [pDATA_WIDTH-1:0] nxt;
  logic                   upd_wrap;
  logic                   do_wr;

  // Addresses beyond the last entry (non power-of-2 depth) and a hardwired R0 are not backed by storage.
  function automatic logic addr_ok(input logic [pADDR_WIDTH-1:0] a);
    return (int'({1'b0, a}) < pDEPTH) && !((pZERO_R0 != 0) && (a == '0));
  endfunction

  assign do_wr = iwe && !iclr && addr_ok(iwaddr);
  assign cur   = addr_ok(iwaddr) ? mem[iwaddr] : '0;

  common_regfile_upd #(
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_upd (
    .cur   (cur),
    .iwdata(iwdata),
    .iop   (iop),
    .nxt   (nxt),
    .wrap  (upd_wrap)
  );

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      mem      <= '{default: '0};
      owritten <= '0;
      owrap    <= 1'b0;
    end else if (iclr) begin
      mem      <= '{default: '0};
      owritten <= '0;
      owrap    <= 1'b0;
    end else begin
      owrap <= do_wr && upd_wrap;
      if (do_wr) begin
        mem[iwaddr]      <= nxt;
        owritten[iwaddr] <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [pADDR_WIDTH-1:0] ra;
    logic [pDATA_WIDTH-1:0] rd;
    assign ra = (p == 0) ? iraddr_a : iraddr_b;
    always_comb begin
      rd = '0;
      if (addr_ok(ra)) begin
        rd = mem[ra];
        if ((pBYPASS != 0) && do_wr && (ra == iwaddr)) rd = nxt;
      end
    end
  end

  assign ordata_a = g_rd[0].rd;
  assign ordata_b = g_rd[1].rd;

endmodule

// File: tb/tb_common_regfile.sv
// Scoreboard bench for common_regfile: three configurations (default, no-bypass/zero-R0, depth 5).
module tb_common_regfile;
  import common_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        clr [3];
  logic        we  [3];
  regfile_op_e op  [3];
  logic [2:0]  wa  [3];
  logic [7:0]  wd  [3];
  logic [2:0]  ra  [3];
  logic [2:0]  rb  [3];
  logic [7:0]  rda [3];
  logic [7:0]  rdb [3];
  logic        wrp [3];
  logic [7:0]  wrn0, wrn1;
  logic [4:0]  wrn2;

  typedef struct {
    int         cyc;
    int         d;
    int         s;
    logic [7:0] exp;
    string      name;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  common_regfile #(.pDEPTH(8), .pBYPASS(1), .pZERO_R0(0)) u_d0 (
    .iclk(clk), .irst_n(rst_n), .iclr(clr[0]), .iwe(we[0]), .iop(op[0]),
    .iwaddr(wa[0]), .iwdata(wd[0]), .iraddr_a(ra[0]), .ordata_a(rda[0]),
    .iraddr_b(rb[0]), .ordata_b(rdb[0]), .owrap(wrp[0]), .owritten(wrn0));

  common_regfile #(.pDEPTH(8), .pBYPASS(0), .pZERO_R0(1)) u_d1 (
    .iclk(clk), .irst_n(rst_n), .iclr(clr[1]), .iwe(we[1]), .iop(op[1]),
    .iwaddr(wa[1]), .iwdata(wd[1]), .iraddr_a(ra[1]), .ordata_a(rda[1]),
    .iraddr_b(rb[1]), .ordata_b(rdb[1]), .owrap(wrp[1]), .owritten(wrn1));

  common_regfile #(.pDEPTH(5), .pBYPASS(1), .pZERO_R0(0)) u_d2 (
    .iclk(clk), .irst_n(rst_n), .iclr(clr[2]), .iwe(we[2]), .iop(op[2]),
    .iwaddr(wa[2]), .iwdata(wd[2]), .iraddr_a(ra[2]), .ordata_a(rda[2]),
    .iraddr_b(rb[2]), .ordata_b(rdb[2]), .owrap(wrp[2]), .owritten(wrn2));

  // s: 0 = read A, 1 = read B, 2 = wrap flag, 3 = written mask
  function automatic logic [7:0] getv(int d, int s);
    case (s)
      0: return rda[d];
      1: return rdb[d];
      2: return {7'b0, wrp[d]};
      default: begin
        if (d == 0) return wrn0;
        if (d == 1) return wrn1;
        return {3'b0, wrn2};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [7:0] act;
        act = getv(sb[i].d, sb[i].s);
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic exp_now(int d, int s, logic [7:0] e, string n);
    sb.push_back('{cyc, d, s, e, n});
  endtask

  task automatic exp_next(int d, int s, logic [7:0] e, string n);
    sb.push_back('{cyc + 1, d, s, e, n});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      we[d]  = 1'b0;
      clr[d] = 1'b0;
    end
  endtask

  task automatic wr(int d, regfile_op_e o, logic [2:0] a, logic [7:0] v);
    we[d] = 1'b1;
    op[d] = o;
    wa[d] = a;
    wd[d] = v;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      clr[d] = 1'b0; we[d] = 1'b0; op[d] = OP_LOAD;
      wa[d] = '0; wd[d] = '0; ra[d] = '0; rb[d] = '0;
    end
    tick(); tick();
    rst_n = 1'b1;
    ra[0] = 3'd3; rb[0] = 3'd7;
    exp_now(0, 0, 8'h00, "reset_rd_a");
    exp_now(0, 1, 8'h00, "reset_rd_b");
    exp_now(0, 3, 8'h00, "reset_written");
    exp_now(0, 2, 8'h00, "reset_wrap");
    exp_now(1, 3, 8'h00, "reset_written_d1");

    // LOAD r3 with bypass visible in the same cycle
    tick(); wr(0, OP_LOAD, 3'd3, 8'hA5); ra[0] = 3'd3;
    exp_now(0, 0, 8'hA5, "load_bypass");
    tick(); ra[0] = 3'd3;
    exp_now(0, 0, 8'hA5, "load_r3");
    exp_now(0, 3, 8'h08, "load_written");

    // Wrap sequence on r2
    tick(); wr(0, OP_LOAD, 3'd2, 8'hFF);
    tick(); wr(0, OP_INC, 3'd2, 8'h00); ra[0] = 3'd2; rb[0] = 3'd3;
    exp_now(0, 0, 8'h00, "inc_ff_bypass");
    exp_now(0, 1, 8'hA5, "port_b_indep");
    exp_now(0, 2, 8'h00, "wrap_before_inc");
    tick(); wr(0, OP_DEC, 3'd2, 8'h00);
    exp_now(0, 2, 8'h01, "wrap_after_inc");
    exp_now(0, 0, 8'hFF, "dec_00_bypass");
    tick(); wr(0, OP_INC, 3'd2, 8'h00);
    exp_now(0, 2, 8'h01, "wrap_after_dec");
    exp_now(0, 0, 8'h00, "inc_again_bypass");
    tick(); wr(0, OP_INC, 3'd2, 8'h00);
    exp_now(0, 2, 8'h01, "wrap_after_inc2");
    exp_now(0, 0, 8'h01, "inc_nowrap_bypass");
    tick();
    exp_now(0, 2, 8'h00, "wrap_nowrap_inc");
    exp_now(0, 0, 8'h01, "r2_final");
    exp_now(0, 3, 8'h0C, "written_r2_r3");

    // Bypass vs no bypass on r5
    tick(); wr(0, OP_LOAD, 3'd5, 8'h10); wr(1, OP_LOAD, 3'd5, 8'h10);
    tick(); wr(0, OP_INC, 3'd5, 8'h00); wr(1, OP_INC, 3'd5, 8'h00);
    ra[0] = 3'd5; rb[0] = 3'd5; ra[1] = 3'd5; rb[1] = 3'd5;
    exp_now(0, 0, 8'h11, "byp_a");
    exp_now(0, 1, 8'h11, "byp_b");
    exp_now(1, 0, 8'h10, "nobyp_a");
    exp_now(1, 1, 8'h10, "nobyp_b");
    tick();
    exp_now(0, 0, 8'h11, "byp_a_after");
    exp_now(1, 0, 8'h11, "nobyp_a_after");
    exp_now(1, 1, 8'h11, "nobyp_b_after");
    exp_now(1, 3, 8'h20, "nobyp_written");

    // Hardwired R0
    tick(); wr(1, OP_LOAD, 3'd0, 8'h55); ra[1] = 3'd0;
    exp_now(1, 0, 8'h00, "r0_load_same");
    tick(); wr(1, OP_DEC, 3'd0, 8'h00);
    exp_now(1, 0, 8'h00, "r0_after_load");
    exp_now(1, 2, 8'h00, "r0_wrap_load");
    tick();
    exp_now(1, 2, 8'h00, "r0_wrap_dec");
    exp_now(1, 3, 8'h20, "r0_written");
    exp_now(1, 0, 8'h00, "r0_after_dec");

    // Odd depth: invalid addresses
    tick(); wr(2, OP_LOAD, 3'd4, 8'h77);
    tick(); wr(2, OP_LOAD, 3'd6, 8'h99); ra[2] = 3'd6; rb[2] = 3'd4;
    exp_now(2, 0, 8'h00, "d5_rd_inval_wr");
    exp_now(2, 1, 8'h77, "d5_r4");
    tick(); wr(2, OP_DEC, 3'd5, 8'h00); ra[2] = 3'd6; rb[2] = 3'd7;
    exp_now(2, 0, 8'h00, "d5_rd6");
    exp_now(2, 1, 8'h00, "d5_rd7");
    exp_now(2, 3, 8'h10, "d5_written");
    tick(); rb[2] = 3'd4;
    exp_now(2, 2, 8'h00, "d5_wrap_inval");
    exp_now(2, 1, 8'h77, "d5_r4_kept");

    // iclr beats a concurrent write
    tick(); clr[0] = 1'b1; wr(0, OP_LOAD, 3'd1, 8'h33); ra[0] = 3'd3; rb[0] = 3'd1;
    exp_now(0, 0, 8'hA5, "clr_cycle_rd");
    exp_now(0, 1, 8'h00, "clr_no_bypass");
    tick(); ra[0] = 3'd1; rb[0] = 3'd3;
    exp_now(0, 0, 8'h00, "clr_r1");
    exp_now(0, 1, 8'h00, "clr_r3");
    exp_now(0, 3, 8'h00, "clr_written");
    exp_now(0, 2, 8'h00, "clr_wrap");

    // Async reset in the middle of a wrapping INC
    tick(); wr(0, OP_LOAD, 3'd6, 8'hFF); ra[0] = 3'd0; rb[0] = 3'd0;
    tick(); wr(0, OP_INC, 3'd6, 8'h00);
    #3 rst_n = 1'b0;
    tick(); rst_n = 1'b1; ra[0] = 3'd6; rb[0] = 3'd6;
    exp_now(0, 0, 8'h00, "rst_mid_inc_a");
    exp_now(0, 1, 8'h00, "rst_mid_inc_b");
    exp_now(0, 2, 8'h00, "rst_mid_inc_wrap");
    exp_now(0, 3, 8'h00, "rst_mid_inc_written");
    tick();
    exp_now(0, 2, 8'h00, "rst_wrap_after");

    tick(); tick();
    checks++;
    if (rda[0] !== 8'h00) begin
      errors++;
      $display("FAIL final_rd_a: got 0x%02h expected 0x00", rda[0]);
    end
    checks++;
    if (rdb[0] !== 8'h00) begin
      errors++;
      $display("FAIL final_rd_b: got 0x%02h expected 0x00", rdb[0]);
    end
    checks++;
    if (wrp[0] !== 1'b0) begin
      errors++;
      $display("FAIL final_wrap: got %0b expected 0", wrp[0]);
    end
    checks++;
    if (wrn0 !== 8'h00) begin
      errors++;
      $display("FAIL final_written: got 0x%02h expected 0x00", wrn0);
    end
    checks++;
    if (wrn2 !== 5'h00) begin
      errors++;
      $display("FAIL final_written_d5: got 0x%02h expected 0x00", wrn2);
    end
    checks++;
    if (rdb[2] !== 8'h00) begin
      errors++;
      $display("FAIL final_d5_r4_reset: got 0x%02h expected 0x00", rdb[2]);
    end
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never compared, expected 0x%02h", sb[0].name, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
